doble_dabble_inverso: RTL and testbench

Sequential BCD-to-binary converter implementing the reverse double-dabble (shift-right / subtract-3) algorithm. It accepts a three-digit BCD value (hundreds, tens, units) on a start pulse and returns the 10-bit binary equivalent after a fixed number of cycles. It is the return path for the team's binary-to-BCD display logic: digits entered or stored in BCD are converted back to binary for arithmetic.

---
 rtl/doble_dabble_inverso_pkg.sv | 21 ++
 rtl/doble_dabble_inverso_if.sv | 24 ++
 rtl/doble_dabble_inverso_ajuste_bcd.sv | 10 +
 rtl/doble_dabble_inverso.sv | 125 ++++++++++++
 tb/tb_doble_dabble_inverso.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/doble_dabble_inverso_pkg.sv
// Shared widths, iteration count and FSM state type for the BCD-to-binary
// converter (reverse double-dabble).
package doble_dabble_pkg;

  localparam int ANCHO_BIN      = 10;
  localparam int ANCHO_BCD      = 12;
  localparam int N_ITER         = 10;
  localparam int ANCHO_TRABAJO  = ANCHO_BCD + ANCHO_BIN;
  localparam int ANCHO_CONT     = 4;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    CONVIERTE = 2'd1,
    FIN       = 2'd2
  } estado_t;

  function automatic logic digito_invalido(input logic [3:0] digito);
    return digito > 4'd9;
  endfunction

endpackage

// File: rtl/doble_dabble_inverso_if.sv
// Start/digit/result bundle between a BCD source and the converter.
interface doble_dabble_inverso_if;
  import doble_dabble_pkg::*;

  logic                 Inicio;
  logic [3:0]           Centenas;
  logic [3:0]           Decenas;
  logic [3:0]           Unidades;
  logic [ANCHO_BIN-1:0] Binario;
  logic                 Ocupado;
  logic                 Listo;
  logic                 Error;

  modport master (
    output Inicio, Centenas, Decenas, Unidades,
    input  Binario, Ocupado, Listo, Error
  );

  modport slave (
    input  Inicio, Centenas, Decenas, Unidades,
    output Binario, Ocupado, Listo, Error
  );

endinterface

// File: rtl/doble_dabble_inverso_ajuste_bcd.sv
// Nibble corrector for the reverse double-dabble: a digit that reads 8 or more
// after the right shift carried a half-ten in, so 3 is subtracted to compensate.
module ajuste_bcd (
  input  logic [3:0] in,
  output logic [3:0] out
);

  assign out = (in >= 4'd8) ? (in - 4'd3) : in;

endmodule

// File: rtl/doble_dabble_inverso.sv
// Sequential three-digit BCD to 10-bit binary converter: one shift/correct
// step per cycle over a 22-bit working register, 11 cycles start to result.
module doble_dabble_inverso
  import doble_dabble_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  doble_dabble_inverso_if.slave   bus
);

  estado_t                  estado;
  estado_t                  estado_sig;
  logic [ANCHO_TRABAJO-1:0] trabajo;
  logic [ANCHO_TRABAJO-1:0] desplazado;
  logic [ANCHO_TRABAJO-1:0] trabajo_sig;
  logic [ANCHO_CONT-1:0]    contador;
  logic                     error_latch;
  logic [ANCHO_BIN-1:0]     binario_q;
  logic                     listo_q;
  logic                     error_q;
  logic [3:0]               corr_c;
  logic [3:0]               corr_d;
  logic [3:0]               corr_u;
  logic                     digitos_malos;
  logic                     cargar;
  logic                     iterar;
  logic                     terminar;
  logic                     ocupado;

  assign digitos_malos = digito_invalido(bus.Centenas) |
                         digito_invalido(bus.Decenas)  |
                         digito_invalido(bus.Unidades);

  // The correction acts on the already shifted value, all in one cycle.
  assign desplazado = trabajo >> 1;

  ajuste_bcd u_ajuste_c (.in(desplazado[21:18]), .out(corr_c));
  ajuste_bcd u_ajuste_d (.in(desplazado[17:14]), .out(corr_d));
  ajuste_bcd u_ajuste_u (.in(desplazado[13:10]), .out(corr_u));

  assign trabajo_sig = {corr_c, corr_d, corr_u, desplazado[ANCHO_BIN-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado <= REPOSO;
    end else begin
      estado <= estado_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO: begin
        if (bus.Inicio) begin
          estado_sig = digitos_malos ? FIN : CONVIERTE;
        end
      end
      CONVIERTE: begin
        if (contador == ANCHO_CONT'(1)) begin
          estado_sig = FIN;
        end
      end
      FIN:     estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  always_comb begin
    cargar   = 1'b0;
    iterar   = 1'b0;
    terminar = 1'b0;
    ocupado  = 1'b0;
    case (estado)
      REPOSO: begin
        cargar = bus.Inicio;
      end
      CONVIERTE: begin
        iterar  = 1'b1;
        ocupado = 1'b1;
      end
      FIN: begin
        terminar = 1'b1;
        ocupado  = 1'b1;
      end
      default: begin
        cargar = 1'b0;
      end
    endcase
  end

  // Results are held until the next accepted start clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trabajo     <= '0;
      contador    <= '0;
      error_latch <= 1'b0;
      binario_q   <= '0;
      listo_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      listo_q <= 1'b0;
      if (cargar) begin
        trabajo     <= {bus.Centenas, bus.Decenas, bus.Unidades, {ANCHO_BIN{1'b0}}};
        contador    <= ANCHO_CONT'(N_ITER);
        error_latch <= digitos_malos;
        binario_q   <= '0;
        error_q     <= 1'b0;
      end else if (iterar) begin
        trabajo  <= trabajo_sig;
        contador <= contador - ANCHO_CONT'(1);
      end else if (terminar) begin
        listo_q   <= 1'b1;
        binario_q <= error_latch ? '0 : trabajo[ANCHO_BIN-1:0];
        error_q   <= error_latch;
      end
    end
  end

  assign bus.Binario = binario_q;
  assign bus.Listo   = listo_q;
  assign bus.Error   = error_q;
  assign bus.Ocupado = ocupado;

endmodule

// File: tb/tb_doble_dabble_inverso.sv
// Scoreboard bench for doble_dabble_inverso: starts push expected results,
// a negedge monitor pops and compares whenever Listo is seen.
module tb_doble_dabble_inverso;
  import doble_dabble_pkg::*;

  typedef struct {
    int bin;
    bit err;
    int due;
  } esperado_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  esperado_t cola[$];

  doble_dabble_inverso_if bus();

  doble_dabble_inverso dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
    checks++;
    if (actual !== esperado) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", nombre, actual, esperado, cyc);
    end
  endtask

  function automatic esperado_t modelo(input int c, input int d, input int u, input int k);
    esperado_t e;
    e.err = (c > 9) || (d > 9) || (u > 9);
    e.bin = e.err ? 0 : (100 * c + 10 * d + u);
    e.due = e.err ? (k + 1) : (k + 11);
    return e;
  endfunction

  // Waits for idle, pulses Inicio for one edge, optionally records the expectation.
  task automatic applyStimulus(input int c, input int d, input int u, input bit registrar, output int k);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.Ocupado === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) checkOutput("idle_timeout", 32'd1, 32'd0);
    bus.Inicio   = 1'b1;
    bus.Centenas = 4'(c);
    bus.Decenas  = 4'(d);
    bus.Unidades = 4'(u);
    @(posedge clk);
    #1;
    k = cyc;
    if (registrar) cola.push_back(modelo(c, d, u, k));
    @(negedge clk);
    bus.Inicio   = 1'b0;
    bus.Centenas = 4'($urandom_range(0, 15));
    bus.Decenas  = 4'($urandom_range(0, 15));
    bus.Unidades = 4'($urandom_range(0, 15));
  endtask

  task automatic esperarVacio();
    int n;
    n = 0;
    while (cola.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (cola.size() != 0) begin
      checkOutput("drain_timeout", 32'(cola.size()), 32'd0);
      cola.delete();
    end
    @(negedge clk);
  endtask

  initial begin : monitor
    esperado_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.Listo === 1'b1) begin
        if (cola.size() == 0) begin
          checkOutput("unexpected_listo", 32'd1, 32'd0);
        end else begin
          e = cola.pop_front();
          checkOutput("binario", 32'(bus.Binario), 32'(e.bin));
          checkOutput("error", 32'(bus.Error), 32'(e.err));
          checkOutput("latency", 32'(cyc), 32'(e.due));
          if (!e.err) checkOutput("bcd_residue", 32'(dut.trabajo[21:10]), 32'd0);
        end
      end
    end
  end

  initial begin : estimulo
    int k;
    int n_ocup;
    int guarda;
    int c, d, u;
    esperado_t e;

    bus.Inicio   = 1'b1;
    bus.Centenas = 4'd2;
    bus.Decenas  = 4'd5;
    bus.Unidades = 4'd5;
    repeat (3) @(negedge clk);
    checkOutput("reset_ocupado", 32'(bus.Ocupado), 32'd0);
    checkOutput("reset_listo", 32'(bus.Listo), 32'd0);
    checkOutput("reset_binario", 32'(bus.Binario), 32'd0);
    checkOutput("reset_error", 32'(bus.Error), 32'd0);
    bus.Inicio = 1'b0;
    rst = 1'b0;

    // 255 with busy-window measurement
    applyStimulus(2, 5, 5, 1'b1, k);
    n_ocup = 0;
    guarda = 0;
    while (bus.Listo !== 1'b1 && guarda < 50) begin
      if (bus.Ocupado === 1'b1) n_ocup++;
      @(negedge clk);
      guarda++;
    end
    checkOutput("ocupado_cycles", 32'(n_ocup), 32'd11);
    checkOutput("ocupado_at_listo", 32'(bus.Ocupado), 32'd0);
    esperarVacio();

    applyStimulus(9, 9, 9, 1'b1, k);
    applyStimulus(0, 0, 0, 1'b1, k);
    esperarVacio();

    // invalid digit, then a valid start clears Error
    applyStimulus(1, 10, 3, 1'b1, k);
    esperarVacio();
    checkOutput("error_held", 32'(bus.Error), 32'd1);
    applyStimulus(0, 0, 7, 1'b1, k);
    checkOutput("error_cleared_on_start", 32'(bus.Error), 32'd0);
    esperarVacio();
    checkOutput("binario_held", 32'(bus.Binario), 32'd7);

    // second pulse mid-conversion must be ignored
    applyStimulus(1, 2, 3, 1'b1, k);
    repeat (3) @(negedge clk);
    bus.Inicio   = 1'b1;
    bus.Centenas = 4'd9;
    bus.Decenas  = 4'd9;
    bus.Unidades = 4'd9;
    @(negedge clk);
    bus.Inicio = 1'b0;
    esperarVacio();
    repeat (15) @(negedge clk);

    // Inicio held high: one result every 12 cycles
    c = $urandom_range(0, 9);
    d = $urandom_range(0, 9);
    u = $urandom_range(0, 9);
    @(negedge clk);
    bus.Inicio   = 1'b1;
    bus.Centenas = 4'(c);
    bus.Decenas  = 4'(d);
    bus.Unidades = 4'(u);
    @(posedge clk);
    #1;
    k = cyc;
    for (int j = 0; j < 3; j++) begin
      e = modelo(c, d, u, k + 12 * j);
      cola.push_back(e);
    end
    repeat (24) @(posedge clk);
    @(negedge clk);
    bus.Inicio = 1'b0;
    esperarVacio();

    // asynchronous abort, Inicio ignored during reset, restart right after release
    applyStimulus(4, 5, 6, 1'b0, k);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_ocupado", 32'(bus.Ocupado), 32'd0);
    checkOutput("abort_listo", 32'(bus.Listo), 32'd0);
    checkOutput("abort_binario", 32'(bus.Binario), 32'd0);
    checkOutput("abort_error", 32'(bus.Error), 32'd0);
    bus.Inicio   = 1'b1;
    bus.Centenas = 4'd0;
    bus.Decenas  = 4'd4;
    bus.Unidades = 4'd2;
    repeat (2) @(negedge clk);
    checkOutput("reset_ignores_inicio", 32'(bus.Ocupado), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    k = cyc;
    cola.push_back(modelo(0, 4, 2, k));
    @(negedge clk);
    bus.Inicio = 1'b0;
    esperarVacio();

    // exhaustive valid sweep
    for (int ci = 0; ci < 10; ci++)
      for (int di = 0; di < 10; di++)
        for (int ui = 0; ui < 10; ui++)
          applyStimulus(ci, di, ui, 1'b1, k);
    esperarVacio();

    // random digits including invalid nibbles
    for (int i = 0; i < 150; i++) begin
      applyStimulus($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1'b1, k);
    end
    esperarVacio();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
